// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle: fetch stage is master, memory is slave.
// One outstanding request; im_req&im_gnt is the accept, im_valid returns the word later.
interface if_fetch_stage_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_valid;
  logic [31:0] im_rdata;

  modport master (output im_req, im_addr, input im_gnt, im_valid, im_rdata);
  modport slave  (input im_req, im_addr, output im_gnt, im_valid, im_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, single-outstanding imem master, IF/ID register; IF_PERF_CNT_EN adds fetch/bubble counters.
// Response loads IF/ID on its arrival edge; IFStall holds IF/ID and PC, a skid buffer absorbs a response arriving under stall.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  if_fetch_stage_if.master    imem,
  input  logic                IFStall,
  input  logic                BranchTaken,
  input  logic [31:0]         BranchTarget,
  output logic [31:0]         IF_pcout,
  output logic [31:0]         IF_instrout,
  output logic                IF_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_bubbles
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  logic [2:0]  state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] skid_q, skid_n;
  logic        req_q;
  logic        deliver, flush, bubble;
  logic [31:0] deliver_dat;

  assign imem.im_req  = req_q;
  assign imem.im_addr = pc_q;
  assign deliver_dat  = (state_q == S_HOLD) ? skid_q : imem.im_rdata;

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    skid_n  = skid_q;
    deliver = 1'b0;
    flush   = 1'b0;
    bubble  = 1'b0;
    if (BranchTaken) begin
      // A grant or response coinciding with the redirect belongs to the old path.
      flush  = 1'b1;
      pc_n   = {BranchTarget[31:2], 2'b00};
      skid_n = '0;
      case (state_q)
        S_REQ:   state_n = imem.im_gnt ? S_DROP : S_REQ;
        S_WAIT:  state_n = imem.im_valid ? S_REQ : S_DROP;
        S_DROP:  state_n = imem.im_valid ? S_REQ : S_DROP;
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_n = S_REQ;
        S_REQ:  if (imem.im_gnt) state_n = S_WAIT;
        S_WAIT: begin
          if (imem.im_valid) begin
            if (IFStall) begin
              skid_n  = imem.im_rdata;
              state_n = S_HOLD;
            end else begin
              deliver = 1'b1;
              state_n = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!IFStall) begin
            deliver = 1'b1;
            state_n = S_REQ;
          end
        end
        S_DROP:  if (imem.im_valid) state_n = S_REQ;
        default: state_n = S_IDLE;
      endcase
      bubble = !IFStall && !deliver;
      if (deliver) pc_n = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      skid_q      <= '0;
      req_q       <= 1'b0;
      IF_pcout    <= '0;
      IF_instrout <= NOP_INSTR;
      IF_valid    <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      skid_q  <= skid_n;
      req_q   <= (state_n == S_REQ);
      if (deliver) begin
        IF_pcout    <= pc_q;
        IF_instrout <= deliver_dat;
        IF_valid    <= 1'b1;
      end else if (flush || bubble) begin
        IF_instrout <= NOP_INSTR;
        IF_valid    <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_q, bubbles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (deliver)          fetched_q <= fetched_q + 32'd1;
      if (flush || bubble)  bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule
